// File: rtl/trace_capture.sv
`default_nettype none
// trace_capture: samples the core's reg-write and data-memory strobes, encodes them
// as trace records and buffers them in a 2-write/1-read show-ahead FIFO for a host.
module trace_capture #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cap_en,
    input  logic                      clr,
    input  logic                      reg_write_sig,
    input  logic [4:0]                reg_num,
    input  logic [DATA_W-1:0]         reg_data,
    input  logic                      wr,
    input  logic                      rd,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [DATA_W-1:0]         rd_data,
    output logic                      trc_valid,
    input  logic                      trc_ready,
    output logic [1:0]                trc_type,
    output logic [ADDR_W-1:0]         trc_idx,
    output logic [DATA_W-1:0]         trc_data,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [15:0]               drop_cnt,
    output logic                      overflow,
    output logic                      proto_err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_REC_W = 2 + ADDR_W + DATA_W;

    localparam logic [1:0] c_TYPE_REG  = 2'b01;
    localparam logic [1:0] c_TYPE_MEMW = 2'b10;
    localparam logic [1:0] c_TYPE_MEMR = 2'b11;

    localparam logic [c_LVL_W:0] c_DEPTH_EXT = (c_LVL_W + 1)'(DEPTH);

    // Record layout: {type, idx, data}
    logic [c_REC_W-1:0] mem_q [DEPTH];

    logic [c_PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [c_LVL_W-1:0] level_q,    level_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic               overflow_q, overflow_d;
    logic               proto_q,    proto_d;

    logic               w_mem_ev;
    logic               w_reg_ev;
    logic [c_REC_W-1:0] w_mem_rec;
    logic [c_REC_W-1:0] w_reg_rec;
    logic [c_REC_W-1:0] w_rec0;
    logic [c_REC_W-1:0] w_rec1;
    logic               w_pop;
    logic [c_LVL_W:0]   w_free;
    logic [1:0]         w_n_req;
    logic               w_push0;
    logic               w_push1;
    logic [1:0]         w_n_push;
    logic [1:0]         w_n_drop;
    logic [16:0]        w_drop_sum;
    logic [c_PTR_W-1:0] w_wr_ptr1;
    logic [c_REC_W-1:0] w_head;

    // ---------------- event decode ----------------
    assign w_mem_ev  = cap_en & (wr | rd);
    assign w_reg_ev  = cap_en & reg_write_sig & (reg_num != 5'd0);
    assign w_mem_rec = {(wr ? c_TYPE_MEMW : c_TYPE_MEMR), addr, (wr ? wr_data : rd_data)};
    assign w_reg_rec = {c_TYPE_REG, ADDR_W'(reg_num), reg_data};

    // The mem record always takes the first slot so it survives a one-slot shortage.
    assign w_rec0 = w_mem_ev ? w_mem_rec : w_reg_rec;
    assign w_rec1 = w_reg_rec;

    // ---------------- space and push/drop accounting ----------------
    assign trc_valid = (level_q != '0);
    assign w_pop     = trc_valid & trc_ready;
    assign w_free    = c_DEPTH_EXT - {1'b0, level_q} + (c_LVL_W + 1)'(w_pop);
    assign w_n_req   = {1'b0, w_mem_ev} + {1'b0, w_reg_ev};
    assign w_push0   = ~clr & (w_n_req != 2'd0) & (w_free != '0);
    assign w_push1   = ~clr & (w_n_req == 2'd2) & (w_free >= (c_LVL_W + 1)'(2));
    assign w_n_push  = {1'b0, w_push0} + {1'b0, w_push1};
    assign w_n_drop  = w_n_req - w_n_push;
    assign w_drop_sum = {1'b0, drop_cnt_q} + 17'(w_n_drop);
    assign w_wr_ptr1 = wr_ptr_q + c_PTR_W'(1);

    always_comb begin
        wr_ptr_d   = wr_ptr_q + c_PTR_W'(w_n_push);
        rd_ptr_d   = rd_ptr_q + c_PTR_W'(w_pop);
        level_d    = level_q + c_LVL_W'(w_n_push) - c_LVL_W'(w_pop);
        drop_cnt_d = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        overflow_d = overflow_q | (w_n_drop != 2'd0);
        proto_d    = proto_q | (cap_en & wr & rd);
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            drop_cnt_d = '0;
            overflow_d = 1'b0;
            proto_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
            proto_q    <= proto_d;
        end
    end

    // Storage needs no reset: outputs are gated by trc_valid.
    always_ff @(posedge clk) begin
        if (w_push0) begin
            mem_q[wr_ptr_q] <= w_rec0;
        end
        if (w_push1) begin
            mem_q[w_wr_ptr1] <= w_rec1;
        end
    end

    // ---------------- show-ahead head ----------------
    assign w_head     = mem_q[rd_ptr_q];
    assign trc_type   = trc_valid ? w_head[c_REC_W-1 -: 2]  : 2'b00;
    assign trc_idx    = trc_valid ? w_head[DATA_W +: ADDR_W] : '0;
    assign trc_data   = trc_valid ? w_head[DATA_W-1:0]       : '0;
    assign fifo_level = level_q;
    assign drop_cnt   = drop_cnt_q;
    assign overflow   = overflow_q;
    assign proto_err  = proto_q;

endmodule
`default_nettype wire
